btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer with per-entry 2-bit direction counters, replacing the direct-mapped, 1-bit BTB in the IF stage. It is looked up combinationally with the IF-stage word PC. It is updated from EX with the resolved outcome and target of every branch or jump. After reset, an internal sweep clears it one set per cycle, so the arrays can be mapped to RAM.

---
 rtl/btb_assoc_if.sv | 55 +++++
 rtl/btb_assoc.sv | 204 ++++++++++++++++++++
 tb/tb_btb_assoc.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_if.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc_if
// Description : Lookup/update bundle between the fetch/execute stages and the
//               set-associative branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface btb_assoc_if #(
  parameter int PC_W  = 30,
  parameter int TGT_W = 32
);

  // IF-stage lookup
  logic [PC_W-1:0]  pc_if;
  logic             pred_hit;
  logic             pred_taken;
  logic [TGT_W-1:0] pred_target;

  // Sweep status
  logic             ready;

  // EX-stage resolution
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [TGT_W-1:0] upd_target;

  // Pipeline side: issues lookups and updates, consumes predictions
  modport master (
    output pc_if,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    input  pred_hit,
    input  pred_taken,
    input  pred_target,
    input  ready
  );

  // Buffer side
  modport slave (
    input  pc_if,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    output pred_hit,
    output pred_taken,
    output pred_target,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc
// Description : Set-associative branch target buffer with 2-bit saturating
//               direction counters and per-set round-robin replacement.
//               Combinational lookup, single-edge update, and a post-reset
//               sweep that clears one set per cycle so the arrays carry no
//               reset and can be mapped onto RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_assoc #(
  parameter int SET_LEN = 6,
  parameter int WAYS    = 2,
  parameter int TAG_LEN = 7,
  parameter int PC_W    = 30,
  parameter int TGT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  btb_assoc_if.slave  bus
);

  localparam int SET_SIZE = 1 << SET_LEN;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAY_W-1:0]   LAST_WAY = WAY_W'(WAYS - 1);
  localparam logic [SET_LEN-1:0] LAST_SET = SET_LEN'(SET_SIZE - 1);
  localparam logic [1:0]         CTR_INIT = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t             state;
  logic [SET_LEN-1:0] clr_idx;
  logic               ready_r;

  // --------------------------------------------------------------------------
  // Storage: no reset on any array; valid and rr are cleared by the sweep
  // --------------------------------------------------------------------------
  logic               valid_arr [SET_SIZE][WAYS];
  logic [TAG_LEN-1:0] tag_arr   [SET_SIZE][WAYS];
  logic [TGT_W-1:0]   tgt_arr   [SET_SIZE][WAYS];
  logic [1:0]         ctr_arr   [SET_SIZE][WAYS];
  logic [WAY_W-1:0]   rr_arr    [SET_SIZE];

  // --------------------------------------------------------------------------
  // Address field extraction
  // --------------------------------------------------------------------------
  logic [SET_LEN-1:0] lk_set;
  logic [TAG_LEN-1:0] lk_tag;
  logic [SET_LEN-1:0] up_set;
  logic [TAG_LEN-1:0] up_tag;

  assign lk_set = bus.pc_if[SET_LEN-1:0];
  assign lk_tag = bus.pc_if[SET_LEN+TAG_LEN-1:SET_LEN];
  assign up_set = bus.upd_pc[SET_LEN-1:0];
  assign up_tag = bus.upd_pc[SET_LEN+TAG_LEN-1:SET_LEN];

  // PC bits above the tag are deliberately not stored (aliasing is allowed)
  if (SET_LEN + TAG_LEN < PC_W) begin : g_unused_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^{bus.pc_if[PC_W-1:SET_LEN+TAG_LEN],
                            bus.upd_pc[PC_W-1:SET_LEN+TAG_LEN]};
  end

  // --------------------------------------------------------------------------
  // Lookup path
  // --------------------------------------------------------------------------
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;
  logic             live;

  // Tag compare across the set; scanning high-to-low leaves the lowest match
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[lk_set][w] && (tag_arr[lk_set][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // Array contents are meaningless until the sweep has finished
  assign live            = (state == ST_READY);
  assign bus.pred_hit    = live & lk_hit;
  assign bus.pred_taken  = live & lk_hit & ctr_arr[lk_set][lk_way][1];
  assign bus.pred_target = (live & lk_hit) ? tgt_arr[lk_set][lk_way] : '0;
  assign bus.ready       = ready_r;

  // --------------------------------------------------------------------------
  // Update path
  // --------------------------------------------------------------------------
  logic             up_hit;
  logic [WAY_W-1:0] up_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] rr_cur;
  logic [WAY_W-1:0] rr_next;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;
  logic             upd_ok;

  // Hit detection and lowest-invalid-way search for the update set
  always_comb begin
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[up_set][w] && (tag_arr[up_set][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!valid_arr[up_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Victim choice, round-robin advance and saturating counter arithmetic
  always_comb begin
    rr_cur  = rr_arr[up_set];
    rr_next = (rr_cur == LAST_WAY) ? '0 : rr_cur + WAY_W'(1);
    victim  = inv_found ? inv_way : rr_cur;
    ctr_cur = ctr_arr[up_set][up_way];
    ctr_inc = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
    ctr_dec = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
  end

  // Reset beats a coincident update; updates are ignored during the sweep
  assign upd_ok = !rst && (state == ST_READY) && bus.upd_valid;

  // --------------------------------------------------------------------------
  // Sweep sequencer
  // --------------------------------------------------------------------------
  // CLEAR walks every set once after reset, then READY holds until next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + SET_LEN'(1);
          if (clr_idx == LAST_SET) begin
            state   <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        ST_READY: begin
          state   <= ST_READY;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= ST_CLEAR;
          clr_idx <= '0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Array writes
  // --------------------------------------------------------------------------
  // Sweep clears valid/rr of one set; otherwise apply the resolved outcome
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_CLEAR)) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_arr[clr_idx][w] <= 1'b0;
      end
      rr_arr[clr_idx] <= '0;
    end else if (upd_ok) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          ctr_arr[up_set][up_way] <= ctr_inc;
          tgt_arr[up_set][up_way] <= bus.upd_target;
        end else begin
          ctr_arr[up_set][up_way] <= ctr_dec;
        end
      end else if (bus.upd_taken) begin
        valid_arr[up_set][victim] <= 1'b1;
        tag_arr[up_set][victim]   <= up_tag;
        tgt_arr[up_set][victim]   <= bus.upd_target;
        ctr_arr[up_set][victim]   <= CTR_INIT;
        if (!inv_found) begin
          rr_arr[up_set] <= rr_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_assoc
// Description : Scoreboard bench for btb_assoc: directed stimulus pushes the
//               expected lookup response, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_assoc;

  logic clk;
  logic rst;

  btb_assoc_if #(.PC_W(30), .TGT_W(32)) bus ();

  btb_assoc #(
    .SET_LEN (6),
    .WAYS    (2),
    .TAG_LEN (7),
    .PC_W    (30),
    .TGT_W   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic chk_now;
  int   n_checks;
  int   n_pass;

  // Monitor: one expectation is consumed per flagged cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_now) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL scoreboard_empty: got an output cycle, required a queued expectation");
      end else begin
        e = q.pop_front();
        if (bus.pred_hit === e.hit && bus.pred_taken === e.taken &&
            bus.pred_target === e.tgt && bus.ready === e.rdy) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got hit=%b taken=%b tgt=%h ready=%b, required hit=%b taken=%b tgt=%h ready=%b",
                   e.name, bus.pred_hit, bus.pred_taken, bus.pred_target, bus.ready,
                   e.hit, e.taken, e.tgt, e.rdy);
        end
      end
    end
  end

  // Advance one cycle and apply new inputs just after the edge
  task automatic drive(input logic uv, input logic [29:0] up, input logic ut,
                       input logic [31:0] utg, input logic [29:0] pc);
    @(posedge clk);
    #1;
    bus.upd_valid  = uv;
    bus.upd_pc     = up;
    bus.upd_taken  = ut;
    bus.upd_target = utg;
    bus.pc_if      = pc;
    chk_now        = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic h, input logic t,
                            input logic [31:0] tg, input logic r);
    exp_t x;
    x.name  = nm;
    x.hit   = h;
    x.taken = t;
    x.tgt   = tg;
    x.rdy   = r;
    q.push_back(x);
    chk_now = 1'b1;
  endtask

  // Release reset and walk the 64-cycle sweep; optionally hammer updates
  task automatic sweep(input logic [29:0] pc, input bit every_cycle);
    for (int i = 0; i < 64; i++) begin
      drive(every_cycle || (i == 10), pc, 1'b1, 32'h5555, pc);
      if (i == 0) rst = 1'b0;
      expect_out("sweep_busy", 1'b0, 1'b0, 32'h0, 1'b0);
    end
    drive(1'b0, 30'h0, 1'b0, 32'h0, pc);
    expect_out("sweep_done_update_dropped", 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Hysteresis sequence at 0x40 and the predicted direction before each step
  logic [6:0] hyst_ops;
  logic [6:0] hyst_pre;

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    chk_now        = 1'b0;
    rst            = 1'b1;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    bus.pc_if      = 30'h40;
    hyst_ops       = 7'b1111000;   // index 0 first: NT,NT,NT,T,T,T,T
    hyst_pre       = 7'b1100001;   // ctr before: 2,1,0,0,1,2,3

    // Reset state
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h40);
    expect_out("reset_state", 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h40);
    expect_out("reset_state", 1'b0, 1'b0, 32'h0, 1'b0);

    // Sweep: ready after exactly 64 cycles, update in cycle 10 ignored
    sweep(30'h80, 1'b0);

    // Allocate then hit; lookup in the update cycle sees the old contents
    drive(1'b1, 30'h40, 1'b1, 32'h1000, 30'h40);
    expect_out("alloc_same_cycle_miss", 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h40);
    expect_out("alloc_hit", 1'b1, 1'b1, 32'h1000, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h840);
    expect_out("same_set_other_tag", 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h2040);
    expect_out("upper_pc_bits_alias", 1'b1, 1'b1, 32'h1000, 1'b1);

    // Counter hysteresis, back-to-back updates, lookup shows pre-update ctr
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 30'h40, hyst_ops[k], 32'h1000, 30'h40);
      expect_out("hysteresis", 1'b1, hyst_pre[k], 32'h1000, 1'b1);
    end
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h40);
    expect_out("hysteresis_saturated", 1'b1, 1'b1, 32'h1000, 1'b1);

    // No bypass: new target visible only from the next cycle
    drive(1'b1, 30'h40, 1'b1, 32'h2000, 30'h40);
    expect_out("no_bypass_old_target", 1'b1, 1'b1, 32'h1000, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h40);
    expect_out("new_target", 1'b1, 1'b1, 32'h2000, 1'b1);

    // Replacement in set 5: A,B fill, C evicts A, D evicts B
    drive(1'b1, 30'h045, 1'b1, 32'h0A, 30'h0);
    drive(1'b1, 30'h085, 1'b1, 32'h0B, 30'h0);
    drive(1'b1, 30'h0C5, 1'b1, 32'h0C, 30'h0);
    drive(1'b1, 30'h105, 1'b1, 32'h0D, 30'h0);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h045);
    expect_out("repl_A_evicted", 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h085);
    expect_out("repl_B_evicted", 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h0C5);
    expect_out("repl_C_hit", 1'b1, 1'b1, 32'h0C, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h105);
    expect_out("repl_D_hit", 1'b1, 1'b1, 32'h0D, 1'b1);

    // Not-taken miss allocates nothing
    drive(1'b1, 30'h007, 1'b0, 32'h77, 30'h0);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h007);
    expect_out("nt_miss_no_alloc", 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset during back-to-back updates: 0x9 lands, 0x3 is dropped
    drive(1'b1, 30'h009, 1'b1, 32'h99, 30'h0);
    drive(1'b1, 30'h003, 1'b1, 32'h33, 30'h009);
    rst = 1'b1;
    expect_out("rst_cycle_lookup_live", 1'b1, 1'b1, 32'h99, 1'b1);
    sweep(30'h003, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h009);
    expect_out("after_resweep_cleared", 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h040);
    expect_out("after_resweep_cleared", 1'b0, 1'b0, 32'h0, 1'b1);

    // Drain and make sure every expectation was consumed
    drive(1'b0, 30'h0, 1'b0, 32'h0, 30'h0);
    @(posedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d leftover, required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
